// File: rtl/msk_diff_mod_pkg.sv
// Shared types and elaboration-time helpers for the MSK transmit modulator.
package msk_tx_pkg;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // Per-sample phase increment: a quarter turn spread over one symbol.
  function automatic int msk_step(int pw, int sps);
    return (1 << (pw - 2)) / sps;
  endfunction

  // Quarter-wave cosine table entry k of 2^aw+1, amplitude 2^(ow-1)-1.
  function automatic int lut_entry(int k, int aw, int ow);
    real amp, x;
    amp = real'((1 << (ow - 1)) - 1);
    x   = amp * $cos(3.14159265358979323846 / 2.0 * real'(k) / real'(1 << aw));
    return $rtoi(x + 0.5);
  endfunction

endpackage

// File: rtl/msk_diff_mod_if.sv
// Bit-in / IQ-out bundle between the framer side and the modulator.
interface msk_diff_mod_if #(parameter int OW = 18);
  logic                 data_i;
  logic                 data_valid_i;
  logic                 data_ready_o;
  logic                 samp_en_i;
  logic signed [OW-1:0] i_o;
  logic signed [OW-1:0] q_o;
  logic                 sample_valid_o;
  logic                 sym_start_o;
  logic                 active_o;
  logic [15:0]          underflow_cnt_o;

  modport master (output data_i, data_valid_i, samp_en_i,
                  input  data_ready_o, i_o, q_o, sample_valid_o, sym_start_o,
                         active_o, underflow_cnt_o);
  modport slave  (input  data_i, data_valid_i, samp_en_i,
                  output data_ready_o, i_o, q_o, sample_valid_o, sym_start_o,
                         active_o, underflow_cnt_o);
endinterface

// File: rtl/msk_sincos_lut.sv
// Registered phase -> (cos, sin) using a quarter-wave table with quadrant folding.
module msk_sincos_lut
  import msk_tx_pkg::*;
#(
  parameter int PW     = 12,
  parameter int LUT_AW = 8,
  parameter int OW     = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PW-1:0]        phase_i,
  output logic signed [OW-1:0] cos_o,
  output logic signed [OW-1:0] sin_o
);
  localparam int N = 1 << LUT_AW;

  logic signed [OW-1:0] rom [N+1];
  logic [1:0]           quad;
  logic [LUT_AW:0]      idx_c, idx_s;
  logic signed [OW-1:0] c, s, cos_d, sin_d, cos_q, sin_q;

  for (genvar k = 0; k <= N; k++) begin : g_rom
    assign rom[k] = OW'(lut_entry(k, LUT_AW, OW));
  end

  if (PW - 2 > LUT_AW) begin : g_trunc
    logic unused_lsb;
    assign unused_lsb = ^phase_i[PW-3-LUT_AW:0];
  end

  assign quad  = phase_i[PW-1 -: 2];
  assign idx_c = {1'b0, phase_i[PW-3 -: LUT_AW]};
  // sin of the in-quadrant angle is cos of its complement
  assign idx_s = (LUT_AW+1)'(N) - idx_c;
  assign c     = rom[idx_c];
  assign s     = rom[idx_s];

  always_comb begin
    cos_d = c;
    sin_d = s;
    unique case (quad)
      QUAD_0: begin cos_d =  c; sin_d =  s; end
      QUAD_1: begin cos_d = -s; sin_d =  c; end
      QUAD_2: begin cos_d = -c; sin_d = -s; end
      QUAD_3: begin cos_d =  s; sin_d = -c; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

  assign cos_o = cos_q;
  assign sin_o = sin_q;
endmodule

// File: rtl/msk_diff_mod.sv
// MSK modulator: one-entry bit holding register, symbol FSM, phase accumulator, IQ output.
module msk_diff_mod
  import msk_tx_pkg::*;
#(
  parameter int OW     = 18,
  parameter int SPS    = 4,
  parameter int PW     = 12,
  parameter int LUT_AW = 8
) (
  input logic           clk,
  input logic           reset,
  msk_diff_mod_if.slave bus
);
  localparam int STEP   = msk_step(PW, SPS);
  localparam int NW     = $clog2(SPS);
  localparam int STAGES = 2;

  state_e               state_q, state_d;
  logic [NW-1:0]        n_q, n_d;
  logic [PW-1:0]        ph_q, ph_d;
  logic                 cur_q, cur_d;
  logic                 nxt_bit_q, nxt_bit_d, nxt_full_q, nxt_full_d;
  logic                 rdy_en_q;
  logic [15:0]          uf_q, uf_d;
  logic                 bnd, consume, accept, ss0;
  logic [STAGES:1]      vld_pipe, ss_pipe;
  logic signed [OW-1:0] lut_cos, lut_sin, i_q, q_q;

  assign accept = bus.data_valid_i && bus.data_ready_o;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    ph_d    = ph_q;
    cur_d   = cur_q;
    uf_d    = uf_q;
    bnd     = 1'b0;
    consume = 1'b0;
    ss0     = 1'b0;
    if (bus.samp_en_i) begin
      bnd = (state_q == IDLE) || (n_q == NW'(SPS - 1));
      if (state_q == ACTIVE) begin
        ss0  = (n_q == '0);
        ph_d = cur_q ? ph_q + PW'(STEP) : ph_q - PW'(STEP);
        n_d  = n_q + 1'b1;
      end
      if (bnd) begin
        n_d = '0;
        if (nxt_full_q) begin
          consume = 1'b1;
          cur_d   = nxt_bit_q;
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
          // idle-to-idle boundaries are not starvation
          if (state_q == ACTIVE && uf_q != 16'hFFFF) uf_d = uf_q + 16'd1;
        end
      end
    end
  end

  assign nxt_full_d = accept || (nxt_full_q && !consume);
  assign nxt_bit_d  = accept ? bus.data_i : nxt_bit_q;

  msk_sincos_lut #(.PW(PW), .LUT_AW(LUT_AW), .OW(OW)) u_lut (
    .clk     (clk),
    .reset   (reset),
    .phase_i (ph_q),
    .cos_o   (lut_cos),
    .sin_o   (lut_sin)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      ph_q       <= '0;
      cur_q      <= 1'b0;
      nxt_bit_q  <= 1'b0;
      nxt_full_q <= 1'b0;
      rdy_en_q   <= 1'b0;
      uf_q       <= '0;
      vld_pipe   <= '0;
      ss_pipe    <= '0;
      i_q        <= '0;
      q_q        <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      ph_q       <= ph_d;
      cur_q      <= cur_d;
      nxt_bit_q  <= nxt_bit_d;
      nxt_full_q <= nxt_full_d;
      rdy_en_q   <= 1'b1;
      uf_q       <= uf_d;
      vld_pipe   <= {vld_pipe[STAGES-1:1], bus.samp_en_i};
      ss_pipe    <= {ss_pipe[STAGES-1:1], ss0};
      if (vld_pipe[1]) begin
        i_q <= lut_cos;
        q_q <= lut_sin;
      end
    end
  end

  assign bus.data_ready_o    = rdy_en_q && !nxt_full_q;
  assign bus.i_o             = i_q;
  assign bus.q_o             = q_q;
  assign bus.sample_valid_o  = vld_pipe[STAGES];
  assign bus.sym_start_o     = ss_pipe[STAGES];
  assign bus.active_o        = (state_q == ACTIVE);
  assign bus.underflow_cnt_o = uf_q;
endmodule

// File: tb/tb_msk_diff_mod.sv
// Bench for msk_diff_mod: symbol-level reference model, directed cases, random loopback slicer.
module tb_msk_diff_mod;
  localparam int OW = 18, SPS = 4, PW = 12, LUT_AW = 8;
  localparam int STEP = (1 << (PW - 2)) / SPS;
  localparam int AMP  = (1 << (OW - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  msk_diff_mod_if #(.OW(OW)) bus();
  msk_diff_mod #(.OW(OW), .SPS(SPS), .PW(PW), .LUT_AW(LUT_AW)) dut (
    .clk(clk), .reset(rst), .bus(bus));

  int n_chk = 0, n_fail = 0;

  task automatic chk(string tag, longint obs, longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model state
  bit hold[$], sent[$], tx_q[$];
  int m_left, m_phase, m_uf;
  bit m_dir, m_rdy, m_acc;
  bit s1_v, s1_ss, o_v, o_ss;
  int s1_i, s1_q, o_i, o_q;
  // slicer / observation state
  int n_starts;
  longint p_i, p_q;
  int obs_si[$], obs_sq[$];

  function automatic int trig(int p, bit sn);
    real th, x;
    int pt;
    pt = p & ~((1 << (PW - 2 - LUT_AW)) - 1);
    th = 2.0 * 3.14159265358979323846 * real'(pt) / real'(1 << PW);
    x  = real'(AMP) * (sn ? $sin(th) : $cos(th));
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  task automatic model_reset();
    hold.delete(); sent.delete();
    m_left = 0; m_phase = 0; m_uf = 0; m_dir = 0; m_rdy = 0; m_acc = 0;
    s1_v = 0; s1_ss = 0; s1_i = 0; s1_q = 0;
    o_v = 0; o_ss = 0; o_i = 0; o_q = 0;
    n_starts = 0; p_i = 0; p_q = 0;
  endtask

  // One clock edge of the spec's behaviour: symbols of SPS samples, 2-cycle output latency.
  task automatic model_edge();
    bit take;
    if (rst) begin model_reset(); return; end
    take = bus.data_valid_i && m_rdy && hold.size() == 0;
    o_v = s1_v; o_ss = s1_ss;
    if (s1_v) begin o_i = s1_i; o_q = s1_q; end
    s1_v = bus.samp_en_i; s1_ss = 0;
    if (bus.samp_en_i) begin
      s1_i = trig(m_phase, 0);
      s1_q = trig(m_phase, 1);
      if (m_left == 0) begin
        if (hold.size() != 0) begin m_dir = hold.pop_front(); m_left = SPS; end
      end else begin
        s1_ss   = (m_left == SPS);
        m_phase = (m_phase + (m_dir ? STEP : (1 << PW) - STEP)) % (1 << PW);
        m_left--;
        if (m_left == 0) begin
          if (hold.size() != 0) begin m_dir = hold.pop_front(); m_left = SPS; end
          else if (m_uf < 16'hFFFF) m_uf++;
        end
      end
    end
    if (take) begin hold.push_back(bus.data_i); sent.push_back(bus.data_i); end
    m_acc = take;
    m_rdy = 1;
  endtask

  task automatic compare();
    longint im;
    chk("sample_valid", bus.sample_valid_o, o_v);
    chk("sym_start", bus.sym_start_o, o_ss);
    chk("i_o", bus.i_o, o_i);
    chk("q_o", bus.q_o, o_q);
    chk("active", bus.active_o, m_left != 0);
    chk("data_ready", bus.data_ready_o, m_rdy && hold.size() == 0);
    chk("underflow", bus.underflow_cnt_o, m_uf);
    if (bus.sample_valid_o && bus.sym_start_o) begin
      obs_si.push_back(bus.i_o);
      obs_sq.push_back(bus.q_o);
      if (n_starts > 0 && n_starts - 1 < sent.size()) begin
        im = longint'(bus.q_o) * p_i - longint'(bus.i_o) * p_q;
        chk("slicer", im > 0, sent[n_starts-1]);
      end
      p_i = bus.i_o; p_q = bus.q_o;
      n_starts++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic step1(bit se, int dv_pct);
    bus.samp_en_i    = se;
    bus.data_valid_i = (tx_q.size() != 0) && ($urandom_range(99) < dv_pct);
    bus.data_i       = (tx_q.size() != 0) ? tx_q[0] : 1'b0;
    cyc();
    if (m_acc) void'(tx_q.pop_front());
  endtask

  task automatic run(int ncyc, int se_per);
    for (int c = 0; c < ncyc; c++)
      step1(se_per > 0 ? (c % se_per == 0) : ($urandom_range(99) < 75), 100);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.data_valid_i = 0; bus.samp_en_i = 0; bus.data_i = 0;
    tx_q.delete();
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    int ei[4], eq[4];
    int c;
    ei = '{AMP, 0, -AMP, 0};
    eq = '{0, AMP, 0, -AMP};
    bus.data_valid_i = 0; bus.samp_en_i = 0; bus.data_i = 0;
    model_reset();

    // idle after reset: constant phasor at phase 0
    do_reset();
    run(12, 4);
    chk("idle_i", bus.i_o, AMP);
    chk("idle_q", bus.q_o, 0);

    // four ones: quarter turn per symbol, wrapping back to 0
    obs_si.delete(); obs_sq.delete();
    tx_q = '{1, 1, 1, 1};
    run(90, 4);
    chk("ones_starts", obs_si.size(), 4);
    for (int k = 0; k < 4 && k < obs_si.size(); k++) begin
      chk($sformatf("ones_start%0d_i", k), obs_si[k], ei[k]);
      chk($sformatf("ones_start%0d_q", k), obs_sq[k], eq[k]);
    end
    chk("ones_underflow", bus.underflow_cnt_o, 1);

    // alternating bits, denser strobe
    tx_q = '{1, 0, 1, 0};
    run(60, 2);

    // stall after three bits, then resume from the frozen phase
    do_reset();
    tx_q = '{1, 1, 1};
    run(70, 4);
    chk("stall_i", bus.i_o, 0);
    chk("stall_q", bus.q_o, -AMP);
    chk("stall_uf", bus.underflow_cnt_o, 1);
    chk("stall_active", bus.active_o, 0);
    obs_si.delete(); obs_sq.delete();
    tx_q = '{1};
    run(30, 4);
    chk("resume_starts", obs_si.size(), 1);
    if (obs_si.size() > 0) begin
      chk("resume_i", obs_si[0], 0);
      chk("resume_q", obs_sq[0], -AMP);
    end

    // valid held high with a sparse strobe: backpressure, no loss or duplication
    for (int b = 0; b < 8; b++) tx_q.push_back(1'($urandom_range(0, 1)));
    run(300, 8);
    chk("hold_drained", tx_q.size(), 0);

    // random loopback through the differential slicer
    do_reset();
    for (int b = 0; b < 2000; b++) tx_q.push_back(1'($urandom_range(0, 1)));
    c = 0;
    while ((tx_q.size() != 0 || hold.size() != 0 || m_left != 0) && c < 40000) begin
      step1($urandom_range(99) < 75, 85);
      c++;
    end
    chk("loop_in_budget", c < 40000, 1);
    run(4, 1);
    chk("loop_syms", n_starts, 2000);

    // asynchronous reset mid-stream
    for (int b = 0; b < 40; b++) tx_q.push_back(1'($urandom_range(0, 1)));
    run(37, 1);
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    chk("arst_i", bus.i_o, 0);
    chk("arst_ready", bus.data_ready_o, 0);
    tx_q.delete();
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    tx_q = '{0, 0, 1};
    run(60, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/msk_diff_mod.md
# msk_diff_mod

Transmit-side MSK modulator. Accepts a hard-bit stream over a valid/ready handshake and emits continuous-phase complex baseband I/Q at SPS samples per symbol. Each bit advances carrier phase by ±π/2 over one symbol, so a one-sample-per-symbol differential slicer, sign of Imag{Sₖ·conj(Sₖ₋₁)}, recovers the bits. Sits between the framer and the DAC interpolation chain, and doubles as the stimulus source for receive-path loopback benches.

## Interface
- OW, 18: signed I/Q output width.
- SPS, 4: samples per symbol. Power of two, 2..64.
- PW, 12: phase accumulator width; 2^PW = one full turn. Requires 2^(PW-2) divisible by SPS.
- LUT_AW, 8: address width of the quarter-wave cosine LUT.

Ports:
- clk, in, 1: sole clock.
- reset, in, 1: asynchronous, active-high reset.
- data_i, in, 1: bit to transmit.
- data_valid_i, in, 1: data_i valid.
- data_ready_o, out, 1: holding register empty; a bit is accepted on data_valid_i && data_ready_o.
- samp_en_i, in, 1: sample-rate strobe; one output sample per strobe.
- i_o, out, OW, signed: in-phase sample.
- q_o, out, OW, signed: quadrature sample.
- sample_valid_o, out, 1: i_o/q_o valid, one pulse per samp_en_i.
- sym_start_o, out, 1: qualifies the sample at n=0 of a symbol.
- active_o, out, 1: FSM in ACTIVE.
- underflow_cnt_o, out, 16: saturating count of symbol boundaries with no bit available.

## Operation
- Holding register: 1 entry (next_bit, next_full). data_ready_o = !next_full.
  - A simultaneous accept and consume leaves next_full = 1 with the new bit.
  - No bypass: a bit is never consumed in its accept cycle.
- Symbol boundary: a samp_en_i with either state IDLE, or state ACTIVE and sample counter n = SPS-1.
- FSM states:
  - IDLE: phase held. At a boundary with next_full, load cur_bit, set n = 0, go to ACTIVE.
  - ACTIVE: on each samp_en_i, output the current phase, then phase += STEP if cur_bit = 1, else phase -= STEP. STEP = 2^(PW-2)/SPS.
  - At n = SPS-1: if next_full, load the next bit and stay in ACTIVE. Otherwise go to IDLE and increment underflow_cnt_o, saturating at 0xFFFF.
- No transition from IDLE to IDLE counts as underflow.
- Phase wraps modulo 2^PW and is never reset between symbols, so phase is continuous.
- IDLE still emits samples: a constant phasor at the held phase, with sample_valid_o following samp_en_i.
- sym_start_o is asserted for the n = 0 sample of every ACTIVE symbol only.
- Sine/cosine generation:
  - Quadrant = phase[PW-1:PW-2]. LUT address = the next LUT_AW bits below the quadrant bits; truncate the remaining LSBs.
  - cos and sin are taken from the quarter LUT using mirror/negate per quadrant.
  - LUT entries are round(A·cos(π/2·k/2^LUT_AW)), with A = 2^(OW-1)-1. This makes outputs symmetric; -2^(OW-1) is never produced.
- Reset:
  - Phase = 0, n = 0, state = IDLE, next_full = 0, underflow_cnt_o = 0.
  - Outputs: i_o = 0, q_o = 0, sample_valid_o = 0, sym_start_o = 0, active_o = 0.
  - data_ready_o = 1 one cycle after reset deasserts; it is 0 while reset is high.
  - Reset mid-symbol abandons the symbol; the first post-reset phase is 0.
- samp_en_i asserted every cycle is legal, provided the bit source keeps up.

## Timing
- Latency: samp_en_i in cycle t gives sample_valid_o, i_o, q_o in cycle t+2 (LUT register, then output register). sym_start_o is aligned to the same cycle.
- i_o/q_o hold their value between valid pulses.
- A bit accepted in cycle t can start a symbol at the first boundary at or after t+1. Its n = 0 sample appears 2 cycles after that boundary.
- active_o is registered and changes in the cycle after the boundary.

## Structure
- Package msk_tx_pkg holds:
  - state enum (IDLE, ACTIVE);
  - STEP and quadrant constants;
  - constant function that builds the quarter-wave LUT contents at elaboration.
- Sub-module msk_sincos_lut (PW, LUT_AW, OW): registered phase-to-(cos, sin) conversion with quadrant folding, latency 1.
- The top contains the holding register, FSM, sample counter, phase accumulator and output register.

## Test plan
- Reset, then idle samp_en_i every 4 cycles → i_o = 131071, q_o = 0, sample_valid_o pulsing, active_o = 0, data_ready_o = 1.
- Bits 1,1,1,1 (SPS = 4) → phase at symbol starts 0, 1024, 2048, 3072, then 0 (wrap). Start samples are (131071, 0), (0, 131071), (-131071, 0), (0, -131071). Intra-symbol step is +256.
- Bits 1,0,1,0 → start phases alternate 0, 1024, 0, 1024. Sample magnitude within ±1 LSB of 131071 on every sample.
- Source stalls after 3 bits → IDLE entered on the next boundary, underflow_cnt_o = 1, output frozen at phase 3072. A new bit resumes from 3072.
- Hold data_valid_i high with samp_en_i sparse → data_ready_o deasserts while the register is full. Exactly one bit is accepted per symbol; no bit is lost or duplicated.
- Loopback: 2000 random bits; feed sym_start_o samples to the differential slicer → its output equals the input bits delayed by one symbol, zero errors. Assert reset mid-stream → outputs return to reset values asynchronously.
